// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Write-side front end for the writable instruction RAM. Bytes arrive from a
// byte source such as a UART or a debug link. The block packs them into
// little-endian words and writes those words to consecutive IMEM addresses,
// starting at address 0. While a load runs, busy holds the CPU in stall.
// When the last word is written, done pulses for one cycle. The block also
// keeps a running XOR of every word it writes. A start with an out-of-range
// word count sets a sticky error flag and does not begin a load.
//
// Ports
//   clk        system clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      one-cycle load request, looked at only while idle
//   num_words  number of words to load (legal range 1..2**ADDR_W)
//   abort      synchronous cancel, honoured in every state
//   in_valid   byte-stream valid
//   in_data    byte-stream data
//   in_ready   high while the loader is collecting bytes
//   we         IMEM write enable, one cycle per word
//   waddr      IMEM word address
//   wdata      IMEM write data (the word being assembled or just assembled)
//   busy       load in progress, drives the CPU stall
//   done       one-cycle pulse after the final word is written
//   err        sticky flag for an illegal num_words
//   checksum   XOR of all words written in the current or last load
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  localparam int BYTES = DATA_W / 8;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W:0] MAX_WORDS = (ADDR_W + 1)'(2 ** ADDR_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e              state_q,    state_d;
  logic [ADDR_W:0]     count_q,    count_d;
  logic [ADDR_W-1:0]   waddr_q,    waddr_d;
  logic [DATA_W-1:0]   wdata_q,    wdata_d;
  logic [IDX_W-1:0]    byteIdx_q,  byteIdx_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                err_q,      err_d;

  logic countLegal;
  logic lastWord;
  logic lastByte;

  // The count is one bit wider than the address. This lets a full-depth load
  // be expressed without ambiguity. It also keeps the last-word compare from
  // aliasing when the address reaches its maximum value.
  assign countLegal = (num_words != '0) && (num_words <= MAX_WORDS);
  assign lastWord   = ({1'b0, waddr_q} == (count_q - (ADDR_W + 1)'(1)));
  assign lastByte   = (byteIdx_q == IDX_W'(BYTES - 1));

  // State and datapath registers. Everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      byteIdx_q  <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      byteIdx_q  <= byteIdx_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic. Abort takes priority over every other transition. On
  // abort the loader returns to idle, drops the partial word and keeps the
  // checksum of the words already written. In WRITE, abort also stops the
  // checksum update, which matches the write strobe being suppressed.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    byteIdx_d  = byteIdx_q;
    checksum_d = checksum_q;
    err_d      = err_q;

    if (abort) begin
      state_d   = IDLE;
      byteIdx_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            if (countLegal) begin
              count_d    = num_words;
              waddr_d    = '0;
              byteIdx_d  = '0;
              checksum_d = '0;
              err_d      = 1'b0;
              state_d    = RECV;
            end else begin
              err_d = 1'b1;
            end
          end
        end

        RECV: begin
          if (in_valid) begin
            // The first byte of a word fills the least significant lane.
            for (int k = 0; k < BYTES; k++) begin
              if (byteIdx_q == IDX_W'(k)) begin
                wdata_d[8*k +: 8] = in_data;
              end
            end
            byteIdx_d = byteIdx_q + IDX_W'(1);
            if (lastByte) begin
              byteIdx_d = '0;
              state_d   = WRITE;
            end
          end
        end

        WRITE: begin
          checksum_d = checksum_q ^ wdata_q;
          if (lastWord) begin
            state_d = DONE;
          end else begin
            waddr_d = waddr_q + ADDR_W'(1);
            state_d = RECV;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Moore outputs decoded from the state register. The only exception is the
  // write strobe, which abort gates in the same cycle. This guarantees that a
  // cancelled load never makes one more write.
  always_comb begin
    in_ready = (state_q == RECV);
    we       = (state_q == WRITE) && !abort;
    busy     = (state_q == RECV) || (state_q == WRITE);
    done     = (state_q == DONE);
  end

  assign waddr    = waddr_q;
  assign wdata    = wdata_q;
  assign err      = err_q;
  assign checksum = checksum_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader.
//
// Each load routine records the writes the load should produce in a queue,
// as (address, word) pairs. It also records the final XOR checksum in a
// second queue. A monitor runs on the falling edge. It pops one expected
// entry for every write strobe and every done pulse it sees, and compares.
// Writes that arrive with nothing expected are reported. So are
// expectations still unmet at the end of the run.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  num_words = '0;
  logic        abort = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  int checks = 0;
  int failures = 0;
  int weSeen = 0;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expWr[$];
  logic [31:0] expDone[$];
  logic [31:0] wordBuf[64];

  imem_loader #(.ADDR_W(6), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .num_words (num_words),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  // Single comparison point, so every check is counted the same way.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Falling-edge monitor. It is independent of the stimulus and consumes
  // expectations as the DUT produces write strobes and done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (we) begin
        weSeen++;
        checkOutput("in_ready_low_on_we", 32'(in_ready), 32'd0);
        checkOutput("write_was_expected", 32'(expWr.size() != 0), 32'd1);
        if (expWr.size() != 0) begin
          wr_t e;
          e = expWr.pop_front();
          checkOutput("waddr", 32'(waddr), 32'(e.addr));
          checkOutput("wdata", wdata, e.data);
        end
      end
      if (done) begin
        checkOutput("done_was_expected", 32'(expDone.size() != 0), 32'd1);
        checkOutput("busy_low_on_done", 32'(busy), 32'd0);
        checkOutput("writes_before_done", 32'(expWr.size()), 32'd0);
        if (expDone.size() != 0) begin
          checkOutput("checksum_on_done", checksum, expDone.pop_front());
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic pulseStart(input logic [6:0] n);
    start     = 1'b1;
    num_words = n;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Present one byte, with optional random idle cycles before it. The task
  // returns 1 time unit after the edge that accepted the byte.
  task automatic sendByte(input logic [7:0] b, input int gapPct);
    logic rdy;
    int   n;
    while (int'($urandom_range(99)) < gapPct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_data  = b;
    n = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) checkOutput("byte_accept_timeout", 32'(rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic sendWords(input int first, input int n, input int gapPct);
    for (int i = first; i < first + n; i++)
      for (int k = 0; k < 4; k++)
        sendByte(wordBuf[i][8*k +: 8], gapPct);
  endtask

  // Reference model: a load of n words writes wordBuf[0..n-1] to addresses
  // 0..n-1 in order. It then reports the XOR of all those words.
  task automatic expectLoad(input int n);
    logic [31:0] chk;
    chk = '0;
    for (int i = 0; i < n; i++) begin
      expWr.push_back('{addr: 6'(i), data: wordBuf[i]});
      chk ^= wordBuf[i];
    end
    expDone.push_back(chk);
  endtask

  task automatic waitIdle();
    int  n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = !busy && !done;
      n++;
    end
    checkOutput("return_to_idle", 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic applyStimulus(input int n, input int gapPct);
    expectLoad(n);
    pulseStart(7'(n));
    sendWords(0, n, gapPct);
    waitIdle();
  endtask

  initial begin
    int wBefore;

    // Reset with random inputs toggling: every output must stay at zero.
    for (int c = 0; c < 4; c++) begin
      start     = 1'($urandom);
      num_words = 7'($urandom);
      in_valid  = 1'($urandom);
      in_data   = 8'($urandom);
      abort     = 1'($urandom);
      @(negedge clk);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_we", 32'(we), 32'd0);
      checkOutput("reset_waddr", 32'(waddr), 32'd0);
      checkOutput("reset_wdata", wdata, 32'd0);
      checkOutput("reset_busy_done_err", 32'({busy, done, err}), 32'd0);
      checkOutput("reset_checksum", checksum, 32'd0);
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0; abort = 1'b0; num_words = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single known word. The write comes one cycle after the last byte,
    // and done follows on the next cycle.
    wordBuf[0] = 32'h0010_0513;
    expectLoad(1);
    pulseStart(7'd1);
    sendWords(0, 1, 0);
    @(negedge clk);
    checkOutput("single_we_latency", 32'(we), 32'd1);
    @(negedge clk);
    checkOutput("single_done", 32'(done), 32'd1);
    checkOutput("single_checksum", checksum, 32'h0010_0513);
    waitIdle();
    checkOutput("single_busy_after", 32'(busy), 32'd0);

    // Illegal counts set err and never start a load. A legal start clears err.
    pulseStart(7'd0);
    @(negedge clk);
    checkOutput("err_count0", 32'(err), 32'd1);
    checkOutput("busy_count0", 32'(busy), 32'd0);
    @(posedge clk); #1;
    pulseStart(7'd65);
    @(negedge clk);
    checkOutput("err_count65", 32'(err), 32'd1);
    checkOutput("busy_count65", 32'(busy), 32'd0);
    @(posedge clk); #1;
    wordBuf[0] = $urandom;
    expectLoad(1);
    pulseStart(7'd1);
    @(negedge clk);
    checkOutput("err_cleared", 32'(err), 32'd0);
    @(posedge clk); #1;
    sendWords(0, 1, 0);
    waitIdle();

    // Abort after 6 bytes of a 3-word load: one write, no done.
    for (int i = 0; i < 3; i++) wordBuf[i] = $urandom;
    expWr.push_back('{addr: 6'd0, data: wordBuf[0]});
    pulseStart(7'd3);
    sendWords(0, 1, 0);
    sendByte(wordBuf[1][7:0], 0);
    sendByte(wordBuf[1][15:8], 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_idle", 32'({busy, done}), 32'd0);
    checkOutput("abort_checksum", checksum, wordBuf[0]);
    @(posedge clk); #1;
    wordBuf[0] = $urandom;
    applyStimulus(1, 0);

    // Abort while in WRITE: the write is suppressed and the checksum stays 0.
    wordBuf[0] = $urandom;
    pulseStart(7'd2);
    sendWords(0, 1, 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checkOutput("abort_write_idle", 32'(busy), 32'd0);
    checkOutput("abort_write_checksum", checksum, 32'd0);
    @(posedge clk); #1;

    // A start raised in the middle of a 2-word load is ignored.
    for (int i = 0; i < 2; i++) wordBuf[i] = $urandom;
    expectLoad(2);
    pulseStart(7'd2);
    sendByte(wordBuf[0][7:0], 0);
    sendByte(wordBuf[0][15:8], 0);
    pulseStart(7'd5);
    sendByte(wordBuf[0][23:16], 0);
    sendByte(wordBuf[0][31:24], 0);
    sendWords(1, 1, 0);
    waitIdle();

    // Full-depth load with random gaps in the byte stream.
    for (int i = 0; i < 64; i++) wordBuf[i] = 32'(i) * 32'h0101_0101;
    wBefore = weSeen;
    applyStimulus(64, 30);
    checkOutput("full_we_count", 32'(weSeen - wBefore), 32'd64);

    // Random loads of random length, with random data and gaps.
    for (int r = 0; r < 5; r++) begin
      int n;
      n = int'($urandom_range(1, 9));
      for (int i = 0; i < n; i++) wordBuf[i] = $urandom;
      applyStimulus(n, int'($urandom_range(0, 50)));
    end

    repeat (5) @(negedge clk);
    checkOutput("leftover_writes", 32'(expWr.size()), 32'd0);
    checkOutput("leftover_done", 32'(expDone.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory: receives a byte stream, assembles 32-bit little-endian words and issues sequential write strobes into a writable instruction RAM.
- Holds the CPU in stall while loading.
- Reports completion, a running XOR checksum and a parameter error.
- Sits between a byte source (UART/debug link) and the IMEM write port.

Parameters:
ADDR_W, 6, word address width; memory depth = 2**ADDR_W = 64 words
DATA_W, 32, word width; bytes per word = DATA_W/8 = 4

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle load request, sampled only in IDLE
num_words  input  ADDR_W+1  words to load, captured on accepted start; legal 1..64
abort  input  1  synchronous cancel, any state
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte
we  output  1  IMEM write enable, one cycle per word
waddr  output  ADDR_W  IMEM word write address
wdata  output  DATA_W  IMEM write data
busy  output  1  load in progress; drives CPU stall
done  output  1  one-cycle pulse after the last word is written
err  output  1  sticky illegal num_words flag
checksum  output  DATA_W  XOR of all words written in current/last load

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE. Outputs: in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, err=0, checksum=0. Internal byte index=0, word count=0.
- Outputs are Moore:
  - we=1 only in WRITE.
  - in_ready=1 only in RECV.
  - busy=1 in RECV and WRITE.
  - done=1 only in DONE.
- IDLE:
  - start=1 with num_words in 1..64: capture count; clear waddr, byte index, checksum and err; go to RECV.
  - start=1 with num_words=0 or >64: set err=1, stay IDLE, no other state changes.
- RECV:
  - A byte is accepted on in_valid & in_ready.
  - Byte k of a word (k=0..3) lands in wdata[8k+7:8k]; first byte received is the LSB.
  - Byte index increments on each accept.
  - Accepting byte 3 wraps the index to 0 and moves to WRITE on the next edge.
  - in_valid=0 holds state indefinitely; no timeout.
- WRITE (exactly 1 cycle):
  - we=1, waddr=current address, wdata=assembled word; in_ready=0, so no byte is lost.
  - checksum <= checksum ^ wdata.
  - If waddr == count-1, go to DONE; else waddr++ and go to RECV.
  - Write latency: we rises the cycle after the 4th byte is accepted.
- DONE: done=1 for one cycle, then IDLE. waddr, wdata and checksum hold until the next accepted start.
- start in RECV/WRITE/DONE is ignored.
- abort=1 (priority over all transitions):
  - Next state is IDLE; partial word discarded; byte index=0.
  - If asserted in WRITE, that cycle's we is suppressed (we = state==WRITE & ~abort) and checksum is not updated.
  - done is not pulsed; checksum holds the value of words already written.
- Address wrap: num_words=64 writes addresses 0..63, then DONE. The 7-bit count compare prevents 6-bit address wraparound.
- rst_n asserted mid-load returns immediately to reset values. Words already written to IMEM are not undone.

Test Plan:
- Reset values: hold rst_n=0 with random inputs. All outputs are 0; in_ready=0.
- Single word: start with num_words=1, bytes 0x13,0x05,0x10,0x00 on consecutive cycles. One cycle after the 4th accept: we=1, waddr=0, wdata=0x00100513. Next cycle done=1 and checksum=0x00100513. Then busy=0.
- Full load with gaps: num_words=64, word i = i*0x01010101, with in_valid randomly deasserted.
  - Exactly 64 we pulses, waddr 0..63 in order, each wdata correct.
  - in_ready=0 on every we cycle.
  - done once; checksum = XOR of all 64 words; no write to address 0 after address 63.
- Illegal count: start with num_words=0, then with num_words=65. err=1, busy=0, no we. A following legal start clears err.
- Abort: num_words=3, send 6 bytes, assert abort.
  - Exactly 1 we (addr 0); no done; state IDLE.
  - A fresh load of 1 word then writes addr 0 with the correct data.
- Start ignored while busy: pulse start with num_words=5 mid-RECV of a 2-word load. Exactly 2 writes, then done.
